// File: rtl/draw_score_if.sv
// VGA timing bus shared by the display pipeline stages.
// The "in" modport is read by a stage and the "out" modport is driven by it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/draw_score.sv
// Score overlay stage: per-frame double-dabble BCD conversion in vblank,
// rendered with the 8x16 digit font at a fixed screen position.
package draw_score_pkg;
  localparam int RGB_B = 12;

  localparam logic [127:0] GLYPH [16] = '{
    128'h00007CC6C6CEDEF6E6C6C67C00000000,
    128'h00001838781818181818187E00000000,
    128'h00007CC6060C183060C0C6FE00000000,
    128'h00007CC606063C060606C67C00000000,
    128'h00000C1C3C6CCCFE0C0C0C1E00000000,
    128'h0000FEC0C0C0FC060606C67C00000000,
    128'h00003860C0C0FCC6C6C6C67C00000000,
    128'h0000FEC606060C183030303000000000,
    128'h00007CC6C6C67CC6C6C6C67C00000000,
    128'h00007CC6C6C67E0606060C7800000000,
    128'h0, 128'h0, 128'h0, 128'h0, 128'h0, 128'h0
  };

  // addr = {char_code, line}; only '0'..'9' carry glyphs
  function automatic logic [7:0] font_line(input logic [10:0] addr);
    logic [127:0] g;
    g = GLYPH[addr[7:4]];
    if (addr[10:8] != 3'b011 || addr[7:4] > 4'd9) g = '0;
    return g[{~addr[3:0], 3'b000} +: 8];
  endfunction
endpackage

module font_rom
  import draw_score_pkg::*;
(
  input  logic        clk,
  input  logic [10:0] addr,
  output logic [7:0]  data
);
  always_ff @(posedge clk) data <= font_line(addr);
endmodule

module draw_score
  import draw_score_pkg::*;
#(
  parameter int               X             = 0,
  parameter int               Y             = 0,
  parameter logic [RGB_B-1:0] FONT_COLOR    = 12'h000,
  parameter int               NUM_DIGITS    = 4,
  parameter int               SCORE_W       = 14,
  parameter int               BLANK_LEADING = 1
)(
  input  logic               clk,
  input  logic               rst,
  vga_if.in                  vga_in,
  input  logic [RGB_B-1:0]   rgb_i,
  input  logic [SCORE_W-1:0] score,
  vga_if.out                 vga_out,
  output logic [RGB_B-1:0]   rgb_o
);
  localparam int HW    = 11;
  localparam int BCD_N = (SCORE_W + 2) / 3;
  localparam int BCD_D = BCD_N > NUM_DIGITS ? BCD_N : NUM_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);
  localparam logic [HW-1:0] XP = HW'(X);
  localparam logic [HW-1:0] YP = HW'(Y);
  localparam logic [HW-1:0] FW = HW'(8 * NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                         state, state_n;
  logic [CNT_W-1:0]               cnt;
  logic [SCORE_W-1:0]             bin;
  logic [4*BCD_D-1:0]             bcd, bcd_adj;
  logic                           sat;
  logic [NUM_DIGITS-1:0][3:0]     digit;
  logic [NUM_DIGITS-1:0]          blank;
  logic                           lead_zero;

  logic [HW-1:0] dx, dy;
  logic          in_field;
  logic [2:0]    idx;
  logic [3:0]    cur_digit;
  logic          cur_blank;
  logic [10:0]   rom_addr;
  logic [7:0]    line_px;

  logic [HW-1:0]    s1_hc, s1_vc;
  logic             s1_hs, s1_vs, s1_hb, s1_vb;
  logic [RGB_B-1:0] s1_rgb;
  logic             s1_draw;
  logic [2:0]       s1_col;

  // subtraction may wrap; the >= guards keep wrapped values out of the field
  assign dx       = vga_in.hcount - XP;
  assign dy       = vga_in.vcount - YP;
  assign in_field = (vga_in.hcount >= XP) && (dx < FW) &&
                    (vga_in.vcount >= YP) && (dy < HW'(16));
  assign idx      = dx[5:3];

  always_comb begin
    lead_zero = 1'b1;
    blank     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lead_zero = lead_zero && (digit[i] == 4'd0);
      blank[i]  = (BLANK_LEADING != 0) && lead_zero &&
                  (i != NUM_DIGITS - 1);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur_digit = digit[i];
        cur_blank = blank[i];
      end
    end
  end

  assign rom_addr = {7'h30 + {3'd0, cur_digit}, dy[3:0]};

  font_rom u_rom (
    .clk  (clk),
    .addr (rom_addr),
    .data (line_px)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hc          <= '0;
      s1_vc          <= '0;
      s1_hs          <= 1'b0;
      s1_vs          <= 1'b0;
      s1_hb          <= 1'b0;
      s1_vb          <= 1'b0;
      s1_rgb         <= '0;
      s1_draw        <= 1'b0;
      s1_col         <= '0;
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      rgb_o          <= '0;
    end else begin
      s1_hc          <= vga_in.hcount;
      s1_vc          <= vga_in.vcount;
      s1_hs          <= vga_in.hsync;
      s1_vs          <= vga_in.vsync;
      s1_hb          <= vga_in.hblnk;
      s1_vb          <= vga_in.vblnk;
      s1_rgb         <= rgb_i;
      s1_draw        <= in_field && !cur_blank;
      s1_col         <= dx[2:0];
      vga_out.hcount <= s1_hc;
      vga_out.vcount <= s1_vc;
      vga_out.hsync  <= s1_hs;
      vga_out.vsync  <= s1_vs;
      vga_out.hblnk  <= s1_hb;
      vga_out.vblnk  <= s1_vb;
      rgb_o          <= (s1_draw && line_px[3'd7 - s1_col]) ?
                        FONT_COLOR : s1_rgb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (vga_in.vblnk && !s1_vb) state_n = LOAD;
      LOAD:    state_n = SHIFT;
      SHIFT:   if (cnt == CNT_W'(SCORE_W - 1)) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_D; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // any nonzero digit above the displayed width means overflow
  always_comb begin
    sat = 1'b0;
    for (int i = NUM_DIGITS; i < BCD_D; i++) begin
      if (bcd[4*i +: 4] != 4'd0) sat = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      bin   <= '0;
      bcd   <= '0;
      digit <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          bin <= score;
          bcd <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          {bcd, bin} <= {bcd_adj, bin} << 1;
          cnt        <= cnt + 1'b1;
        end
        DONE: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            digit[i] <= sat ? 4'd9 : bcd[4*(NUM_DIGITS-1-i) +: 4];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/draw_score.md
Name: draw_score

Overview:
- VGA pipeline stage placed directly downstream of the menu/result text overlay.
- Consumes that stage's vga_if timing bus and rgb stream, and overlays a decimal score of NUM_DIGITS characters in the 8x16 ASCII font at (X,Y).
- The binary score is converted to BCD by a sequential double-dabble engine once per frame, during vertical blank, so the displayed digits never change mid-frame.
- Character pixels come from an internal font_rom instance.

Parameters:
- X, 0: left pixel column of the score field.
- Y, 0: top pixel row of the score field.
- FONT_COLOR, 12'h000: rgb driven on lit glyph pixels.
- NUM_DIGITS, 4: number of decimal digits displayed. Legal range 1..5.
- SCORE_W, 14: width of the binary score input.
- BLANK_LEADING, 1: 1 blanks leading zeros (the least-significant digit is always drawn); 0 draws all digits.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- vga_in  vga_if.in  -  timing bus (hcount, vcount, hsync, vsync, hblnk, vblnk) from the previous stage.
- rgb_i  in  RGB_B  pixel colour from the previous stage.
- score  in  SCORE_W  unsigned binary score; sampled only at conversion start.
- vga_out  vga_if.out  -  timing bus delayed by 2 clocks.
- rgb_o  out  RGB_B  output pixel colour.

Behaviour:
- Reset (synchronous, active-high):
  - All vga_out fields = 0, rgb_o = 0.
  - Conversion FSM goes to IDLE.
  - Displayed digit register = all 0, so the field shows "0" (or all zeros if BLANK_LEADING = 0).
  - The pipeline delay registers are cleared.
- Latency: exactly 2 clocks from vga_in/rgb_i to vga_out/rgb_o for every field, every pixel, inside and outside the score field.
  - Stage 1 registers the timing bus and rgb_i. It computes char_idx = (hcount-X)>>3, char_line = (vcount-Y)[3:0], col = (hcount-X)[2:0] and in_field, and presents addr = {char_code, char_line} to font_rom.
  - Stage 2 receives char_line_pixels from font_rom (1-clock latency). The stage-2 output register selects the colour.
- Field: X <= hcount < X+8*NUM_DIGITS and Y <= vcount < Y+16. Digit 0, the most significant, is leftmost.
- char_code for digit value d is 7'h30+d.
- Pixel select: bit (7-col) of char_line_pixels; bit 7 is the leftmost column.
- rgb_o = FONT_COLOR when in_field, the digit is not blanked, and the selected bit = 1. Otherwise rgb_o = rgb_i (delayed by 2 clocks).
- Blanked digit: every more-significant digit is 0 and the digit is not the least significant one. A blanked digit draws nothing (rgb_i passes through).
- Conversion FSM, states IDLE -> LOAD -> SHIFT -> DONE -> IDLE:
  - IDLE: waits for a rising edge of vga_in.vblnk (previous registered value 0, current value 1).
  - LOAD (1 clk): captures score into the shift register and clears the BCD register.
  - SHIFT (SCORE_W clks): each clock, first every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1. An internal counter counts SCORE_W iterations.
  - DONE (1 clk): applies saturation, then copies the BCD register into the displayed digit register. This is the only point where displayed digits change.
  - Total conversion time = SCORE_W+2 clocks, which is well inside vertical blank.
- Saturation: if score >= 10^NUM_DIGITS, every displayed digit = 9. The BCD register is sized to hold the full conversion of any SCORE_W value before saturation.
- A vblnk rising edge while not in IDLE is ignored. There is no restart and no queuing.
- A score change outside LOAD has no effect until the next frame.
- Reset asserted mid-conversion aborts it. The digit register returns to 0 and the next vblnk rising edge starts a fresh conversion.
- Coordinate arithmetic uses hcount/vcount width. If hcount < X or vcount < Y the pixel is not in the field, and the subtraction must not wrap into the field.

Test Plan:
- Reset, then run frames with score = 0, X = 100, Y = 50 -> one glyph '0' at columns 124..131, rows 50..65; columns 100..123 pass rgb_i through; vga_out equals vga_in delayed by exactly 2 clocks.
- score = 1234, BLANK_LEADING = 1 -> after the first vblnk rising edge plus 16 clks, the digits read 1,2,3,4. Rendered pixels of row Y+3 match font_rom lines for codes 0x31..0x34. Pixels outside the field equal rgb_i delayed by 2.
- score = 12345 with NUM_DIGITS = 4 -> displays 9999. With score = 14'h3FFF -> also 9999.
- score changes from 42 to 7 in the middle of active video -> the rest of that frame still shows 42. The next frame shows 7, with the three left digits blanked.
- A second vblnk pulse injected 5 clks after the first, with a different score -> the result equals the first capture; the FSM returns to IDLE SCORE_W+2 clks after the first edge.
- Reset asserted during SHIFT while score = 999 -> rgb_o and vga_out are 0 on the next clock. The digits show 0 until the next vblnk rising edge, after which they show 999.
